multi_alarm_core: RTL
=====================

# multi_alarm_core

Parametrised alarm-clock core: BCD 24-hour timekeeper, NUM_ALARMS independently programmable alarms, and a ring/snooze/timeout state machine driving the audio enable. Sits between the board-level top and the sound generator; its `ring` output connects directly to the sound block's `aud_en`. Extends the single-alarm top with multiple channels, priority arbitration, an automatic ring timeout and an optional snooze.

## Interface
Parameters:
- NUM_ALARMS, 4: alarm channels. Legal range is 2..16.
- TICK_DIV, 6000000000: clk cycles per minute. Use 100 in simulation.
- RING_MINUTES, 5: minutes of ringing before automatic stop. Legal range is 1..15.
- SNOOZE_MINUTES, 9: snooze length in minutes. Legal range is 1..15.
- SELW, $clog2(NUM_ALARMS): derived. Do not override.

Ports (time words packed {hourdec, hourone, mindec, minone}, 4 bits each):
- clk  in  1  system clock; one clock domain.
- rstn  in  1  asynchronous active-low reset.
- time_load  in  1  single-cycle pulse; loads time_init.
- time_init  in  16  new current time, BCD.
- alarm_wr  in  1  single-cycle pulse; writes the alarm channel selected by alarm_sel.
- alarm_sel  in  SELW  channel index.
- alarm_time  in  16  alarm time, BCD.
- alarm_on  in  1  enable bit written together with alarm_time.
- dismiss  in  1  single-cycle pulse; stops ringing or snoozing.
- snooze  in  1  single-cycle pulse; snoozes while ringing.
- time_now  out  16  current time, BCD.
- alarm_en_mask  out  NUM_ALARMS  per-channel enable bits.
- ring  out  1  audio enable.
- ring_id  out  SELW  channel that caused the current ring or snooze.
- min_tick  out  1  one-cycle pulse at each minute boundary.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. `min_tick` is high while the count equals TICK_DIV-1.
- Time increment on min_tick:
  - minone counts 0..9, carrying into mindec.
  - mindec counts 0..5, carrying into the hour.
  - The hour counts 00..23; 23:59 wraps to 00:00.
- time_load:
  - Takes priority over min_tick in the same cycle.
  - Clears the prescaler and forces the FSM to IDLE.
  - Rejected, with time_now unchanged, if any digit is invalid or the hour is greater than 23. The prescaler is still cleared.
- alarm_wr:
  - Writes alarm_time and alarm_on to channel alarm_sel.
  - Rejected if alarm_time is invalid BCD or alarm_sel ≥ NUM_ALARMS.
  - Writing alarm_on=0 to the channel equal to ring_id while the FSM is in RING or SNOOZE forces IDLE.
- Match detection:
  - A registered flag is set in the cycle after a tick-driven time update only. A time_load never triggers a match.
  - On that flag, each enabled channel whose alarm time equals time_now matches.
  - The lowest matching index wins and is latched into ring_id.
- FSM states IDLE, RING, SNOOZE:
  - IDLE: `ring`=0. A match moves to RING and clears the minute counter.
  - RING: `ring`=1.
    - dismiss moves to IDLE.
    - snooze moves to SNOOZE and clears the minute counter.
    - Each min_tick increments the minute counter. When the counter reaches RING_MINUTES, the FSM moves to IDLE.
  - SNOOZE: `ring`=0.
    - dismiss moves to IDLE.
    - Each min_tick increments the minute counter. When the counter reaches SNOOZE_MINUTES, the FSM moves to RING and clears the counter.
  - Matches arriving in RING or SNOOZE are ignored and not queued.
- Same-cycle priorities:
  - dismiss and snooze together: dismiss wins.
  - time_load together with any FSM event: IDLE wins.
  - A timeout or snooze expiry in the same cycle as a dismiss: the FSM goes to IDLE.

## Timing
- Reset values:
  - time_now = 16'h0000.
  - All alarms = 16'h0000 and disabled; alarm_en_mask = 0.
  - ring = 0, ring_id = 0, min_tick = 0.
  - Prescaler = 0, FSM = IDLE.
- Time update: if min_tick is high in cycle N, time_now shows the new value in cycle N+1.
- Ring latency: when an alarm matches, ring is high from cycle N+2, where N is the min_tick cycle.
- time_load and alarm_wr take effect on the next edge; outputs reflect them one cycle later.
- Pulse handling:
  - dismiss or snooze in cycle M: ring is low from cycle M+1.
  - Inputs are sampled every cycle. A level held longer than one cycle acts on its first cycle only where the state changes; repeated dismiss pulses in IDLE are no-ops.
- Timeout: ring drops in the cycle after the RING_MINUTES-th min_tick following ring entry.
- Snooze expiry: ring rises in the cycle after the SNOOZE_MINUTES-th min_tick in SNOOZE.
- Asynchronous reset mid-ring forces all reset values immediately.

## Configuration
- ALARM_SNOOZE_EN defined:
  - The SNOOZE state and the snooze input are implemented as described.
- ALARM_SNOOZE_EN undefined:
  - The snooze input is ignored and the SNOOZE state is not synthesised.
  - The SNOOZE_MINUTES parameter is unused.
  - RING exits only by dismiss, timeout, channel disable or time_load.

## Test plan
All scenarios use TICK_DIV=4, RING_MINUTES=2, SNOOZE_MINUTES=3.
- Rollover: load 23:59, wait for one min_tick → time_now=16'h0000 one cycle after the tick; ring stays 0.
- Priority: enable ch1 and ch3 at 07:30, load 07:29, wait for one tick → ring=1 two cycles after the tick; ring_id=1.
- Timeout: after the ring in the priority test, apply no input → ring=0 in the cycle after the 2nd subsequent min_tick; FSM returns to IDLE.
- Snooze (ALARM_SNOOZE_EN defined): pulse snooze while ringing → ring=0 next cycle; ring=1 again after 3 ticks. Dismiss and snooze in the same cycle → IDLE.
- Invalid writes:
  - Load 24:00 → rejected; time_now unchanged.
  - alarm_wr with minone=4'hA → rejected; that channel's alarm_en_mask bit unchanged.
  - Disable the ringing channel → ring=0 next cycle.
- Reset mid-ring: assert rstn=0 asynchronously while ring=1 → all outputs take reset values immediately.

Source files
------------

// File: rtl/multi_alarm_core.sv
// multi_alarm_core: BCD 24-hour timekeeper with NUM_ALARMS programmable alarms
// and a ring / snooze / timeout state machine driving the audio enable.
// Optional feature macro: ALARM_SNOOZE_EN (adds the SNOOZE state and snooze input).
module multi_alarm_core #(
    parameter int unsigned     NUM_ALARMS     = 4,
    parameter longint unsigned TICK_DIV       = 64'd6000000000,
    parameter int unsigned     RING_MINUTES   = 5,
    parameter int unsigned     SNOOZE_MINUTES = 9,
    parameter int unsigned     SELW           = $clog2(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  time_load,
    input  logic [15:0]           time_init,
    input  logic                  alarm_wr,
    input  logic [SELW-1:0]       alarm_sel,
    input  logic [15:0]           alarm_time,
    input  logic                  alarm_on,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic [15:0]           time_now,
    output logic [NUM_ALARMS-1:0] alarm_en_mask,
    output logic                  ring,
    output logic [SELW-1:0]       ring_id,
    output logic                  min_tick
);

    localparam int unsigned     PW        = (TICK_DIV > 64'd1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 64'd1);
    localparam int unsigned     CW        = 4;
    localparam logic [CW-1:0]   RING_LAST = CW'(RING_MINUTES - 1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [CW-1:0]   SNZ_LAST  = CW'(SNOOZE_MINUTES - 1);
`endif

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1} state_t;
`endif

    // A time word is legal when every digit is in range and the hour is 00..23.
    function automatic logic time_valid(input logic [15:0] t);
        logic [3:0] hd, ho, md, mo;
        {hd, ho, md, mo} = t;
        return (mo <= 4'd9) && (md <= 4'd5) && (ho <= 4'd9) && (hd <= 4'd2)
               && !((hd == 4'd2) && (ho > 4'd3));
    endfunction

    // One-minute BCD increment with 23:59 -> 00:00 wrap.
    function automatic logic [15:0] time_inc(input logic [15:0] t);
        logic [3:0] hd, ho, md, mo;
        {hd, ho, md, mo} = t;
        if (mo != 4'd9) begin
            mo = mo + 4'd1;
        end else begin
            mo = 4'd0;
            if (md != 4'd5) begin
                md = md + 4'd1;
            end else begin
                md = 4'd0;
                if ((hd == 4'd2) && (ho == 4'd3)) begin
                    hd = 4'd0;
                    ho = 4'd0;
                end else if (ho == 4'd9) begin
                    ho = 4'd0;
                    hd = hd + 4'd1;
                end else begin
                    ho = ho + 4'd1;
                end
            end
        end
        return {hd, ho, md, mo};
    endfunction

    logic [PW-1:0]   pre_cnt;
    logic [PW-1:0]   pre_next;
    logic            match_pend;
    logic [15:0]     alarm_tm [NUM_ALARMS];
    logic            load_ok;
    logic            wr_ok;
    logic            hit;
    logic [SELW-1:0] hit_id;
    logic            kill;
    state_t          state;
    logic [CW-1:0]   min_cnt;

`ifndef ALARM_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = ^{snooze, 4'(SNOOZE_MINUTES)};
`endif

    // Prescaler next value; a time_load restarts the minute.
    always_comb begin
        pre_next = pre_cnt + PW'(1);
        if (time_load || (pre_cnt == PRE_LAST)) begin
            pre_next = '0;
        end
    end

    // Prescaler and registered minute strobe (high while the count is at its last value).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_cnt  <= '0;
            min_tick <= 1'b0;
        end else begin
            pre_cnt  <= pre_next;
            min_tick <= (pre_next == PRE_LAST);
        end
    end

    assign load_ok = time_load && time_valid(time_init);

    // Timekeeper: load has priority over the tick; tick-driven updates arm the match check.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            time_now   <= 16'h0000;
            match_pend <= 1'b0;
        end else begin
            if (load_ok) begin
                time_now <= time_init;
            end else if (!time_load && min_tick) begin
                time_now <= time_inc(time_now);
            end
            match_pend <= min_tick && !time_load;
        end
    end

    assign wr_ok = alarm_wr && time_valid(alarm_time)
                   && ({1'b0, alarm_sel} < (SELW + 1)'(NUM_ALARMS));

    // Alarm channel registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                alarm_tm[i]      <= 16'h0000;
                alarm_en_mask[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                if (wr_ok && (alarm_sel == SELW'(i))) begin
                    alarm_tm[i]      <= alarm_time;
                    alarm_en_mask[i] <= alarm_on;
                end
            end
        end
    end

    // Match arbitration: lowest enabled matching channel wins.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (match_pend && alarm_en_mask[i] && (alarm_tm[i] == time_now)) begin
                hit    = 1'b1;
                hit_id = SELW'(i);
            end
        end
    end

    // Disabling the channel that is ringing or snoozing cancels it.
    assign kill = wr_ok && !alarm_on && (alarm_sel == ring_id) && (state != IDLE);

    // Ring / snooze / timeout state machine with registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ring    <= 1'b0;
            ring_id <= '0;
            min_cnt <= '0;
        end else if (time_load || kill) begin
            state <= IDLE;
            ring  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state   <= RING;
                        ring    <= 1'b1;
                        ring_id <= hit_id;
                        min_cnt <= '0;
                    end
                end
                RING: begin
                    if (dismiss) begin
                        state <= IDLE;
                        ring  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state   <= SNOOZE;
                        ring    <= 1'b0;
                        min_cnt <= '0;
`endif
                    end else if (min_tick) begin
                        if (min_cnt == RING_LAST) begin
                            state <= IDLE;
                            ring  <= 1'b0;
                        end else begin
                            min_cnt <= min_cnt + CW'(1);
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (dismiss) begin
                        state <= IDLE;
                        ring  <= 1'b0;
                    end else if (min_tick) begin
                        if (min_cnt == SNZ_LAST) begin
                            state   <= RING;
                            ring    <= 1'b1;
                            min_cnt <= '0;
                        end else begin
                            min_cnt <= min_cnt + CW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    ring  <= 1'b0;
                end
            endcase
        end
    end

endmodule
